// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate format select encodings shared by the generator and the decoder.
package imm_gen_pkg;
   // 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR uimm, optional), 110/111 reserved
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;
   localparam logic [2:0] IMM_Z = 3'b101;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate extraction and sign extension to XLEN.
// Format 101 (CSR uimm) is decoded only when IMM_GEN_CSR_EN is defined; otherwise it is reserved.
module imm_extract import imm_gen_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      src,
   output logic            illegal,
   output logic [XLEN-1:0] imm
);
   logic [31:0] imm32;
   logic        opcode_unused;
   assign opcode_unused = ^instr[6:0];
   always_comb begin
      illegal = 1'b0;
      case (src)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_CSR_EN
         IMM_Z:   imm32 = {27'b0, instr[19:15]};
`endif
         default: begin
            imm32   = '0;
            illegal = 1'b1;
         end
      endcase
      // bit 31 of every format is already the sign (zero for Z), so widening is uniform
      imm        = {XLEN{imm32[31]}};
      imm[31:0]  = imm32;
   end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate/target generator with valid/ready handshake.
// SKID_EN=1 adds a 2-entry skid for full throughput with registered in_ready; see IMM_GEN_CSR_EN in imm_extract.
module imm_gen_stage import imm_gen_pkg::*; #(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [2:0]      in_imm_src,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);
   localparam int PW = 2*XLEN + 1;
   logic            ext_illegal;
   logic [XLEN-1:0] ext_imm;
   logic [PW-1:0]   new_p, out_q, out_d, skid_q, skid_d;
   logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
   logic            accept, consume, free;
   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr  (in_instr),
      .src    (in_imm_src),
      .illegal(ext_illegal),
      .imm    (ext_imm)
   );
   // reserved formats yield imm=0, so the adder alone gives target=pc
   assign new_p    = {ext_illegal, in_pc + ext_imm, ext_imm};
   assign in_ready = SKID_EN ? in_ready_q : (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid_q && out_ready;
   assign free     = !out_valid_q || consume;
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (free) begin
         out_valid_d  = skid_valid_q || accept;
         out_d        = skid_valid_q ? skid_q : accept ? new_p : out_q;
         skid_valid_d = 1'b0;
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_d       = new_p;
      end
      in_ready_d = !skid_valid_d;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end
   assign out_valid                          = out_valid_q;
   assign {out_illegal, out_target, out_imm} = out_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed checks of imm_gen_stage at XLEN 32/64 with and without the skid buffer.
module tb_imm_gen_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [2:0]  in_imm_src = '0;
   logic [63:0] pc = '0;
   logic        out_ready = 1'b1;
   logic        a_in_ready, a_out_valid, a_ill;
   logic [31:0] a_imm, a_tgt;
   logic        b_in_ready, b_out_valid, b_ill;
   logic [63:0] b_imm, b_tgt;
   logic        c_in_ready, c_out_valid, c_ill;
   logic [31:0] c_imm, c_tgt;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(32), .SKID_EN(1'b1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
      .in_imm_src(in_imm_src), .in_pc(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_imm(a_imm), .out_target(a_tgt), .out_illegal(a_ill));
   imm_gen_stage #(.XLEN(64), .SKID_EN(1'b1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
      .in_imm_src(in_imm_src), .in_pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_imm(b_imm), .out_target(b_tgt), .out_illegal(b_ill));
   imm_gen_stage #(.XLEN(32), .SKID_EN(1'b0)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr),
      .in_imm_src(in_imm_src), .in_pc(pc[31:0]), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_imm(c_imm), .out_target(c_tgt), .out_illegal(c_ill));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic [63:0] p);
      in_valid   = 1'b1;
      in_instr   = instr;
      in_imm_src = src;
      pc         = p;
   endtask

   // one transaction with out_ready high; checks all three DUTs one cycle after accept
   task automatic xact(input string tag, input logic [31:0] instr, input logic [2:0] src,
                       input logic [63:0] p, input logic [63:0] imm, input logic [63:0] tgt,
                       input logic ill);
      @(negedge clk);
      drive(instr, src, p);
      step();
      in_valid = 1'b0;
      check({tag, "_a_valid"}, {63'b0, a_out_valid}, 64'd1);
      check({tag, "_a_imm"}, {32'b0, a_imm}, {32'b0, imm[31:0]});
      check({tag, "_a_tgt"}, {32'b0, a_tgt}, {32'b0, tgt[31:0]});
      check({tag, "_a_ill"}, {63'b0, a_ill}, {63'b0, ill});
      check({tag, "_b_imm"}, b_imm, imm);
      check({tag, "_b_tgt"}, b_tgt, tgt);
      check({tag, "_b_ill"}, {63'b0, b_ill}, {63'b0, ill});
      check({tag, "_c_valid"}, {63'b0, c_out_valid}, 64'd1);
      check({tag, "_c_imm"}, {32'b0, c_imm}, {32'b0, imm[31:0]});
      check({tag, "_c_tgt"}, {32'b0, c_tgt}, {32'b0, tgt[31:0]});
   endtask

   initial begin
      step();
      step();
      check("rst_valid", {63'b0, a_out_valid}, 64'd0);
      check("rst_in_ready", {63'b0, a_in_ready}, 64'd1);
      check("rst_imm", {32'b0, a_imm}, 64'd0);
      check("rst_tgt", {32'b0, a_tgt}, 64'd0);
      check("rst_ill", {63'b0, a_ill}, 64'd0);
      check("rst_b_in_ready", {63'b0, b_in_ready}, 64'd1);
      @(negedge clk);
      rst = 1'b0;

      xact("i_neg", 32'hFFF00093, 3'b000, 64'h100, 64'hFFFFFFFFFFFFFFFF, 64'hFF, 1'b0);
      xact("s_neg", 32'hFE000C23, 3'b001, 64'h300, 64'hFFFFFFFFFFFFFFF8, 64'h2F8, 1'b0);
      xact("b_neg", 32'hFE000EE3, 3'b010, 64'h200, 64'hFFFFFFFFFFFFFFFC, 64'h1FC, 1'b0);
      xact("u_pos", 32'h12345037, 3'b011, 64'h10, 64'h12345000, 64'h12345010, 1'b0);
      xact("u_neg", 32'h800000B7, 3'b011, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0);
      xact("j_pos", 32'h0080006F, 3'b100, 64'h1000, 64'h8, 64'h1008, 1'b0);
      xact("j_wrap", 32'hFFDFF06F, 3'b100, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
      xact("rsv111", 32'hFFFFFFFF, 3'b111, 64'h40, 64'h0, 64'h40, 1'b1);
      xact("rsv110", 32'h800F8073, 3'b110, 64'h44, 64'h0, 64'h44, 1'b1);
`ifdef IMM_GEN_CSR_EN
      xact("z_uimm", 32'h800F8073, 3'b101, 64'h20, 64'h1F, 64'h3F, 1'b0);
`else
      xact("z_rsv", 32'h800F8073, 3'b101, 64'h20, 64'h0, 64'h20, 1'b1);
`endif
      step();
      check("drain_valid", {63'b0, a_out_valid}, 64'd0);

      // simultaneous accept and consume: no bubble between D and E
      @(negedge clk);
      drive(32'h00400093, 3'b000, 64'h0);
      step();
      check("nb_d_imm", {32'b0, a_imm}, 64'd4);
      drive(32'h00500093, 3'b000, 64'h0);
      step();
      in_valid = 1'b0;
      check("nb_e_valid", {63'b0, a_out_valid}, 64'd1);
      check("nb_e_imm", {32'b0, a_imm}, 64'd5);
      check("nb_e_in_ready", {63'b0, a_in_ready}, 64'd1);
      check("nb_c_e_imm", {32'b0, c_imm}, 64'd5);
      step();
      check("nb_drain", {63'b0, a_out_valid}, 64'd0);

      // backpressure: A to output, B to skid, C refused
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'h00100093, 3'b000, 64'h0);
      step();
      check("bp_a_valid", {63'b0, a_out_valid}, 64'd1);
      check("bp_a_imm", {32'b0, a_imm}, 64'd1);
      check("bp_ready_after_a", {63'b0, a_in_ready}, 64'd1);
      check("bp_c_ready_held", {63'b0, c_in_ready}, 64'd0);
      drive(32'h00200093, 3'b000, 64'h0);
      step();
      check("bp_ready_after_b", {63'b0, a_in_ready}, 64'd0);
      check("bp_hold_imm1", {32'b0, a_imm}, 64'd1);
      drive(32'h00300093, 3'b000, 64'h0);
      step();
      check("bp_third_refused", {63'b0, a_in_ready}, 64'd0);
      check("bp_hold_imm2", {32'b0, a_imm}, 64'd1);
      check("bp_hold_valid", {63'b0, a_out_valid}, 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_b_valid", {63'b0, a_out_valid}, 64'd1);
      check("bp_b_imm", {32'b0, a_imm}, 64'd2);
      check("bp_b_in_ready", {63'b0, a_in_ready}, 64'd1);
      check("bp_b64_imm", b_imm, 64'd2);
      step();
      check("bp_empty", {63'b0, a_out_valid}, 64'd0);
      check("bp_c_empty", {63'b0, c_out_valid}, 64'd0);

      // reset with output and skid both full; input offered during reset is dropped
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'h00100093, 3'b000, 64'h0);
      step();
      drive(32'h00200093, 3'b000, 64'h0);
      step();
      check("mr_skid_full", {63'b0, a_in_ready}, 64'd0);
      rst = 1'b1;
      drive(32'h00700093, 3'b000, 64'h0);
      step();
      check("mr_valid", {63'b0, a_out_valid}, 64'd0);
      check("mr_in_ready", {63'b0, a_in_ready}, 64'd1);
      check("mr_b_valid", {63'b0, b_out_valid}, 64'd0);
      rst = 1'b0;
      drive(32'h00300093, 3'b000, 64'h0);
      step();
      in_valid = 1'b0;
      check("mr_post_valid", {63'b0, a_out_valid}, 64'd1);
      check("mr_post_imm", {32'b0, a_imm}, 64'd3);
      out_ready = 1'b1;
      step();
      check("mr_post_drain", {63'b0, a_out_valid}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/imm_gen_stage.md
Name:
imm_gen_stage

Overview:
- Registered, parametrised immediate generator placed between instruction fetch/decode and execute.
- Accepts an instruction, format select and PC over a valid/ready handshake.
- Produces the sign-extended immediate, the PC-relative target (pc + imm) and an illegal-format flag.
- Generalises the combinational generator to XLEN 32/64, adds a proper J encoding, a 2-entry skid buffer and backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SKID_EN, 1, 1 = 2-entry skid buffer (full throughput, registered in_ready); 0 = single register with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  stage can accept input.
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  format select.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts output.
- out_imm  out  XLEN  sign-extended immediate.
- out_target  out  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_illegal  out  1  in_imm_src was a reserved encoding.

Behaviour:
- Single clock, synchronous active-high reset.
- Reset values: out_valid=0, out_imm=0, out_target=0, out_illegal=0, skid entry empty, in_ready=1 (also while rst is held).
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - Latency is exactly 1 cycle from accept to out_valid when the output register is free.
- Output stability: while out_valid && !out_ready, all out_* signals hold stable.
- Format select (in_imm_src):
  - 000 I: instr[31:20]
  - 001 S: {instr[31:25], instr[11:7]}
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - 011 U: {instr[31:12], 12'b0}
  - 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - 101: see Optional Feature.
  - 110, 111: reserved.
- Extension: all formats sign-extend from instr[31] to XLEN, including U when XLEN=64.
- Reserved src: out_illegal=1, out_imm=0, out_target=in_pc.
- Target adder: XLEN-wide, carry discarded; wraps silently (e.g. pc=0, imm=-4 gives 2^XLEN-4).
- Skid buffer (SKID_EN=1):
  - in_ready is a register equal to !skid_full.
  - Accept while output register full and not consumed: transaction goes to the skid entry.
  - Output consumed while skid full: skid entry moves to the output register the next cycle.
  - Simultaneous accept and consume with skid empty: new data loads the output register directly; no bubble.
  - Order is always preserved; no drop, no duplicate.
- SKID_EN=0: in_ready = !out_valid || out_ready (combinational from out_ready).
- Reset mid-operation: the cycle after rst, out_valid=0 and the skid is empty. In-flight transactions are discarded. Input presented during rst is ignored.

Optional Feature:
- Macro: IMM_GEN_CSR_EN.
- Defined: src 101 = Z-type CSR uimm, zero-extended instr[19:15]; out_illegal=0; out_target = in_pc + uimm.
- Undefined: 101 is treated as reserved (out_illegal=1, out_imm=0).

Decomposition:
- Shared package imm_gen_pkg:
  - localparams IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_U=3'b011, IMM_J=3'b100, IMM_Z=3'b101.
  - Encoding comment kept beside the localparams.
- Sub-module imm_extract: combinational (instr, src) -> {illegal, imm[XLEN-1:0]}, reused by the decoder.
- imm_gen_stage itself holds only the handshake, skid and adder logic.

Test Plan:
- I-type, XLEN=32: instr 0xFFF00093, src 000, pc 0x100 -> after 1 cycle out_imm=0xFFFFFFFF, out_target=0x000000FF, out_illegal=0.
- B-type: instr 0xFE000EE3, src 010, pc 0x200 -> out_imm=0xFFFFFFFC, out_target=0x000001FC. J-type: instr 0x0080006F, src 100, pc 0x1000 -> out_imm=8, out_target=0x1008.
- XLEN=64, U-type: instr 0x800000B7, src 011, pc 0 -> out_imm=0xFFFFFFFF80000000.
- Backpressure, SKID_EN=1:
  - Stimulus: out_ready=0; offer 3 back-to-back transactions.
  - Required: first two accepted; in_ready=0 on the third.
  - Release out_ready: outputs emerge in order, one per cycle, none lost.
- Reserved src 111, pc 0x40 -> out_illegal=1, out_imm=0, out_target=0x40. Src 101 with instr[19:15]=0x1F -> imm=0x1F if IMM_GEN_CSR_EN defined, else illegal.
- Reset mid-operation: assert rst with output register and skid full -> next cycle out_valid=0, in_ready=1; first post-reset transaction emerges after exactly 1 cycle.
